// File: rtl/hpdcache_victim_evict.sv
// ============================================================================
// Module   : hpdcache_victim_evict
// Purpose  : Refill-slot allocator. For each refill request it asks the victim
//            selector for a way. If that way holds a valid, dirty line, the
//            line is read word by word from the data array and streamed to the
//            writeback buffer. The chosen way is then granted to the refill.
// Options  : HPDCACHE_VICTIM_EVICT_STATS_EN adds evict_cnt_o, a saturating
//            count of completed dirty evictions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_victim_evict #(
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int WORDS      = 4,
   parameter int WORD_WIDTH = 64,
   localparam int SETW      = $clog2(SETS),
   localparam int WRDW      = $clog2(WORDS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [SETW-1:0]       req_set_i,
   input  logic [WAYS-1:0]       req_dir_valid_i,
   input  logic [WAYS-1:0]       req_dir_dirty_i,
   output logic                  repl_o,
   output logic [SETW-1:0]       repl_set_o,
   output logic [WAYS-1:0]       repl_dir_valid_o,
   output logic                  repl_updt_o,
   input  logic [WAYS-1:0]       victim_way_i,
   output logic                  rd_valid_o,
   output logic [SETW-1:0]       rd_set_o,
   output logic [WAYS-1:0]       rd_way_o,
   output logic [WRDW-1:0]       rd_word_o,
   input  logic [WORD_WIDTH-1:0] rd_data_i,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [WORD_WIDTH-1:0] wb_data_o,
   output logic                  wb_last_o,
   output logic                  grant_valid_o,
   input  logic                  grant_ready_i,
   output logic [SETW-1:0]       grant_set_o,
   output logic [WAYS-1:0]       grant_way_o
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
   ,output logic [31:0]          evict_cnt_o
`endif
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SELECT   = 3'd1;
   localparam logic [2:0] EVICT_RD = 3'd2;
   localparam logic [2:0] EVICT_WB = 3'd3;
   localparam logic [2:0] GRANT    = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [SETW-1:0]       set_q;
   logic [WAYS-1:0]       valid_q;
   logic [WAYS-1:0]       dirty_q;
   logic [WAYS-1:0]       victim_q;
   logic [WRDW-1:0]       cnt_q;
   logic [WORD_WIDTH-1:0] data_q;
   // data_q holds the word read in the previous cycle; wb_valid_o waits on it
   logic                  have_q;

   logic                  evict_sel;
   logic                  last_word;
   logic                  wb_hs;

   assign evict_sel = |(victim_way_i & valid_q & dirty_q);
   assign last_word = (cnt_q == WRDW'(WORDS - 1));
   assign wb_hs     = (state_q == EVICT_WB) && have_q && wb_ready_i;

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (req_valid_i) state_d = SELECT;
         SELECT:   state_d = evict_sel ? EVICT_RD : GRANT;
         EVICT_RD: state_d = EVICT_WB;
         EVICT_WB: if (wb_hs) state_d = last_word ? GRANT : EVICT_RD;
         GRANT:    if (grant_ready_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State, request capture, word counter and read-data staging
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         set_q    <= '0;
         valid_q  <= '0;
         dirty_q  <= '0;
         victim_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         have_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid_i) begin
            set_q   <= req_set_i;
            valid_q <= req_dir_valid_i;
            dirty_q <= req_dir_dirty_i;
         end
         if (state_q == SELECT) begin
            victim_q <= victim_way_i;
            cnt_q    <= '0;
         end
         if (state_q == EVICT_RD) have_q <= 1'b0;
         if (state_q == EVICT_WB) begin
            if (!have_q) begin
               data_q <= rd_data_i;
               have_q <= 1'b1;
            end else if (wb_ready_i) begin
               have_q <= 1'b0;
               if (!last_word) cnt_q <= cnt_q + WRDW'(1);
            end
         end
      end
   end

   // All strobes decode from the registered state; payloads are zero when idle
   assign req_ready_o      = (state_q == IDLE);
   assign repl_o           = (state_q == SELECT);
   assign repl_updt_o      = repl_o;
   assign repl_set_o       = repl_o ? set_q : '0;
   assign repl_dir_valid_o = repl_o ? valid_q : '0;
   assign rd_valid_o       = (state_q == EVICT_RD);
   assign rd_set_o         = rd_valid_o ? set_q : '0;
   assign rd_way_o         = rd_valid_o ? victim_q : '0;
   assign rd_word_o        = rd_valid_o ? cnt_q : '0;
   assign wb_valid_o       = (state_q == EVICT_WB) && have_q;
   assign wb_data_o        = wb_valid_o ? data_q : '0;
   assign wb_last_o        = wb_valid_o && last_word;
   assign grant_valid_o    = (state_q == GRANT);
   assign grant_set_o      = grant_valid_o ? set_q : '0;
   assign grant_way_o      = grant_valid_o ? victim_q : '0;

`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
   logic [31:0] evict_cnt_q;

   // Count completed dirty evictions, saturating at all-ones
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         evict_cnt_q <= '0;
      end else if (wb_hs && last_word && (evict_cnt_q != '1)) begin
         evict_cnt_q <= evict_cnt_q + 32'd1;
      end
   end

   assign evict_cnt_o = evict_cnt_q;
`endif

   // The victim selector must answer with exactly one way
   always_ff @(posedge clk_i) begin
      if (!rst_i && state_q == SELECT) begin
         assert ($onehot(victim_way_i));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_victim_evict.sv
// ============================================================================
// Module   : tb_hpdcache_victim_evict
// Purpose  : Self-checking bench for hpdcache_victim_evict. Refill requests
//            come from a vector table; expected writeback words and grants are
//            queued when a request is driven and compared as the DUT emits
//            them. Backpressure and mid-eviction reset are hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpdcache_victim_evict;

   localparam int WORDS = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [5:0]  req_set_i;
   logic [3:0]  req_dir_valid_i;
   logic [3:0]  req_dir_dirty_i;
   logic        repl_o;
   logic [5:0]  repl_set_o;
   logic [3:0]  repl_dir_valid_o;
   logic        repl_updt_o;
   logic [3:0]  victim_way_i;
   logic        rd_valid_o;
   logic [5:0]  rd_set_o;
   logic [3:0]  rd_way_o;
   logic [1:0]  rd_word_o;
   logic [63:0] rd_data_i = 64'd0;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [63:0] wb_data_o;
   logic        wb_last_o;
   logic        grant_valid_o;
   logic        grant_ready_i;
   logic [5:0]  grant_set_o;
   logic [3:0]  grant_way_o;
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
   logic [31:0] evict_cnt_o;
`endif

   hpdcache_victim_evict #(
      .SETS(64), .WAYS(4), .WORDS(WORDS), .WORD_WIDTH(64)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_set_i(req_set_i), .req_dir_valid_i(req_dir_valid_i),
      .req_dir_dirty_i(req_dir_dirty_i),
      .repl_o(repl_o), .repl_set_o(repl_set_o),
      .repl_dir_valid_o(repl_dir_valid_o), .repl_updt_o(repl_updt_o),
      .victim_way_i(victim_way_i),
      .rd_valid_o(rd_valid_o), .rd_set_o(rd_set_o), .rd_way_o(rd_way_o),
      .rd_word_o(rd_word_o), .rd_data_i(rd_data_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_data_o(wb_data_o), .wb_last_o(wb_last_o),
      .grant_valid_o(grant_valid_o), .grant_ready_i(grant_ready_i),
      .grant_set_o(grant_set_o), .grant_way_o(grant_way_o)
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
      ,.evict_cnt_o(evict_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Data array contents as a function of address
   function automatic logic [63:0] mem(input logic [5:0] s, input logic [3:0] w, input logic [1:0] k);
      return {8'hC0, 10'd0, s, 4'd0, w, 14'd0, k, 16'hBEEF};
   endfunction

   // Data array model: answers one cycle after the read strobe, garbage otherwise
   always @(posedge clk_i)
      rd_data_i <= rd_valid_o ? mem(rd_set_o, rd_way_o, rd_word_o) : 64'hDEAD_DEAD_DEAD_DEAD;

   typedef struct {
      logic [63:0] d;
      logic        last;
   } wb_t;
   wb_t exp_wb[$];

   typedef struct {
      logic [5:0] set;
      logic [3:0] valid;
      logic [3:0] dirty;
      logic [3:0] victim;
      bit         exp_dirty;
      int         gwait;
   } vec_t;
   vec_t vecs[6];

   bit         mon_en = 0;
   bit         bp_en = 0;
   int         bp_cnt, gwait;
   logic [5:0] cur_set;
   logic [3:0] cur_valid, cur_victim;
   bit         cur_dirty;
   int         rd_cnt, wb_hs, repl_cnt, acc, exp_lat;
   bit         grant_done, grant_seen;

   // Monitor: drives the ready inputs for this cycle, then checks outputs
   always @(negedge clk_i) begin
      if (mon_en) begin
         if (bp_en && wb_valid_o && wb_hs == 1 && bp_cnt < 5) begin
            wb_ready_i = 1'b0;
            bp_cnt++;
         end else begin
            wb_ready_i = 1'b1;
         end
         if (grant_valid_o && gwait > 0) begin
            grant_ready_i = 1'b0;
            gwait--;
         end else begin
            grant_ready_i = 1'b1;
         end
         if (repl_o) begin
            repl_cnt++;
            check("repl_updt", repl_updt_o, 1);
            check("repl_set", repl_set_o, cur_set);
            check("repl_dir", repl_dir_valid_o, cur_valid);
         end
         if (rd_valid_o) begin
            check("rd_set", rd_set_o, cur_set);
            check("rd_way", rd_way_o, cur_victim);
            check("rd_word", rd_word_o, rd_cnt);
            check("rd_wb_overlap", wb_valid_o, 0);
            rd_cnt++;
         end
         if (wb_valid_o) begin
            if (exp_wb.size() == 0) begin
               check("wb_unexpected", 1, 0);
            end else begin
               check("wb_data", wb_data_o, exp_wb[0].d);
               check("wb_last", wb_last_o, exp_wb[0].last);
               if (wb_ready_i) begin
                  void'(exp_wb.pop_front());
                  wb_hs++;
               end
            end
         end
         if (grant_valid_o && !grant_done) begin
            check("grant_set", grant_set_o, cur_set);
            check("grant_way", grant_way_o, cur_victim);
            if (!grant_seen) begin
               grant_seen = 1;
               check("grant_latency", cyc - acc, exp_lat);
            end
            if (grant_ready_i) grant_done = 1;
         end
      end
   end

   task automatic check_idle_outs();
      check("idle_req_ready", req_ready_o, 1);
      check("idle_outs", {repl_o, repl_set_o, repl_dir_valid_o, repl_updt_o, rd_valid_o,
                          rd_set_o, rd_way_o, rd_word_o, wb_valid_o, wb_last_o,
                          grant_valid_o, grant_set_o, grant_way_o}, 0);
      check("idle_wb_data", wb_data_o, 0);
   endtask

   // Called just after a falling edge with the DUT idle
   task automatic start_txn(input logic [5:0] s, input logic [3:0] v, input logic [3:0] d,
                            input logic [3:0] w, input bit dirty, input int gw, input int extra);
      check("req_ready", req_ready_o, 1);
      cur_set = s; cur_valid = v; cur_victim = w; cur_dirty = dirty;
      rd_cnt = 0; wb_hs = 0; repl_cnt = 0; bp_cnt = 0; gwait = gw;
      grant_done = 0; grant_seen = 0;
      exp_lat = dirty ? 2 + 3 * WORDS + extra : 2;
      if (dirty)
         for (int k = 0; k < WORDS; k++)
            exp_wb.push_back('{mem(s, w, 2'(k)), k == WORDS - 1});
      req_set_i = s; req_dir_valid_i = v; req_dir_dirty_i = d; victim_way_i = w;
      req_valid_i = 1'b1;
      acc = cyc;
      @(negedge clk_i); #1;
      req_valid_i = 1'b0;
      req_set_i = 6'($urandom);
      req_dir_valid_i = 4'($urandom);
      req_dir_dirty_i = 4'($urandom);
   endtask

   task automatic wait_grant();
      int n = 0;
      while (!grant_done && n < 300) begin
         @(negedge clk_i); #1;
         n++;
      end
      check("grant_timeout", grant_done, 1);
      @(negedge clk_i); #1;
      check("repl_count", repl_cnt, 1);
      check("rd_count", rd_cnt, cur_dirty ? WORDS : 0);
      check("wb_left", exp_wb.size(), 0);
   endtask

   initial begin
      vecs[0] = '{6'd5,  4'b1111, 4'b0000, 4'b0100, 1'b0, 0};
      vecs[1] = '{6'd9,  4'b1111, 4'b0010, 4'b0010, 1'b1, 0};
      vecs[2] = '{6'd12, 4'b0111, 4'b1111, 4'b1000, 1'b0, 3};
      vecs[3] = '{6'd63, 4'b1111, 4'b1111, 4'b0001, 1'b1, 1};
      vecs[4] = '{6'd0,  4'b1010, 4'b1000, 4'b1000, 1'b1, 0};
      vecs[5] = '{6'd33, 4'b1111, 4'b1101, 4'b0010, 1'b0, 0};

      rst_i = 1'b1; req_valid_i = 1'b0; req_set_i = '0; req_dir_valid_i = '0;
      req_dir_dirty_i = '0; victim_way_i = 4'b0001; wb_ready_i = 1'b1; grant_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check_idle_outs();
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
      check("evict_cnt_reset", evict_cnt_o, 0);
`endif
      mon_en = 1;

      for (int i = 0; i < 6; i++) begin
         start_txn(vecs[i].set, vecs[i].valid, vecs[i].dirty, vecs[i].victim,
                   vecs[i].exp_dirty, vecs[i].gwait, 0);
         wait_grant();
      end
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
      check("evict_cnt_table", evict_cnt_o, 3);
`endif

      // Writeback backpressure on word 1
      bp_en = 1;
      start_txn(6'd17, 4'b1111, 4'b1111, 4'b0100, 1'b1, 0, 5);
      wait_grant();
      check("bp_stall_cycles", bp_cnt, 5);
      bp_en = 0;

      // Reset during the writeback of word 2
      start_txn(6'd20, 4'b1111, 4'b0100, 4'b0100, 1'b1, 0, 0);
      begin
         int n = 0;
         while (rd_cnt < 3 && n < 100) begin
            @(negedge clk_i); #1;
            n++;
         end
      end
      check("rst_reach_word2", rd_cnt, 3);
      mon_en = 0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check_idle_outs();
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
      check("evict_cnt_rst", evict_cnt_o, 0);
`endif
      repeat (4) begin
         @(negedge clk_i); #1;
         check("post_rst_quiet", {repl_o, rd_valid_o, wb_valid_o, grant_valid_o}, 0);
      end
      exp_wb.delete();
      mon_en = 1;

      start_txn(6'd40, 4'b1111, 4'b0001, 4'b0001, 1'b1, 0, 0);
      wait_grant();
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
      check("evict_cnt_final", evict_cnt_o, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
